// File: rtl/br_perf_monitor_if.sv
// Report stream port of the branch-predictor performance monitor.
// The monitor drives words out through the master side, and the consumer uses the slave side.
interface br_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_data;
  logic [2:0]       rpt_idx;
  logic             rpt_last;

  modport master (
    output rpt_valid,
    output rpt_data,
    output rpt_idx,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_data,
    input  rpt_idx,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/br_perf_monitor.sv
// Accumulates branch-prediction statistics until the core parks on the halt opcode.
// The counters are then frozen and streamed as a 5-word valid/ready report.
module br_perf_monitor #(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] HALT_INSN   = 32'h0000006F,
  parameter int          HALT_REPEAT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     br_misses_i,
  input  logic                     br_instr_i,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              t_instr_i,
  br_perf_monitor_if.master        rpt,
  output logic                     done_o
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REPORT,
    ST_DONE
  } state_e;

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cycCnt_q,  cycCnt_d;
  logic [CNT_W-1:0]  brCnt_q,   brCnt_d;
  logic [CNT_W-1:0]  missCnt_q, missCnt_d;
  logic [CNT_W-1:0]  spurCnt_q, spurCnt_d;
  logic [CNT_W-1:0]  lastPc_q,  lastPc_d;
  logic [REP_W-1:0]  rep_q,     rep_d;
  logic [2:0]        idx_q,     idx_d;
  logic              valid_q,   valid_d;
  logic              last_q,    last_d;
  logic [CNT_W-1:0]  data_q,    data_d;
  logic              done_q,    done_d;

  logic              isHalt;
  logic [2:0]        nextIdx;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state logic. The report word is preloaded one cycle ahead so rpt_data stays registered.
  always_comb begin
    state_d   = state_q;
    cycCnt_d  = cycCnt_q;
    brCnt_d   = brCnt_q;
    missCnt_d = missCnt_q;
    spurCnt_d = spurCnt_q;
    lastPc_d  = lastPc_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    done_d    = done_q;
    isHalt    = (instr_i == HALT_INSN);
    nextIdx   = idx_q + 3'd1;

    case (state_q)
      ST_RUN: begin
        cycCnt_d = satInc(cycCnt_q);
        if (br_instr_i) begin
          brCnt_d = satInc(brCnt_q);
        end
        if (br_instr_i && br_misses_i) begin
          missCnt_d = satInc(missCnt_q);
          lastPc_d  = CNT_W'(t_instr_i);
        end
        if (!br_instr_i && br_misses_i) begin
          spurCnt_d = satInc(spurCnt_q);
        end
        if (!isHalt) begin
          rep_d = '0;
        end else if (rep_q != REP_W'(HALT_REPEAT)) begin
          rep_d = rep_q + REP_W'(1);
        end
        if (isHalt && (rep_q == REP_W'(HALT_REPEAT - 1))) begin
          state_d = ST_REPORT;
          valid_d = 1'b1;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          data_d  = cycCnt_d;
        end
      end
      ST_REPORT: begin
        if (valid_q && rpt.rpt_ready) begin
          if (idx_q == 3'd4) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = nextIdx;
            last_d = (nextIdx == 3'd4);
            case (nextIdx)
              3'd1:    data_d = brCnt_q;
              3'd2:    data_d = missCnt_q;
              3'd3:    data_d = spurCnt_q;
              default: data_d = lastPc_q;
            endcase
          end
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register; reset also aborts a report stream in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cycCnt_q  <= '0;
      brCnt_q   <= '0;
      missCnt_q <= '0;
      spurCnt_q <= '0;
      lastPc_q  <= '0;
      rep_q     <= '0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycCnt_q  <= cycCnt_d;
      brCnt_q   <= brCnt_d;
      missCnt_q <= missCnt_d;
      spurCnt_q <= spurCnt_d;
      lastPc_q  <= lastPc_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_data  = data_q;
  assign rpt.rpt_idx   = idx_q;
  assign rpt.rpt_last  = last_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_br_perf_monitor.sv
// Bench for br_perf_monitor: directed and random probe traffic scored against a count-based model.
// A second 4-bit instance shares the probe inputs to exercise counter saturation.
module tb_br_perf_monitor;

  localparam logic [31:0] HALT   = 32'h0000006F;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int          REPEAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        brMisses;
  logic        brInstr;
  logic [31:0] instr;
  logic [31:0] tInstr;
  logic        readyBig;
  logic        done;
  logic        doneSmall;

  int errors = 0;
  int checks = 0;

  longint mCyc, mBr, mMiss, mSpur, mPc;
  int     mStreak;
  bit     mRun;

  br_perf_monitor_if #(.CNT_W(32)) bigIf ();
  br_perf_monitor_if #(.CNT_W(4))  smallIf ();

  assign bigIf.rpt_ready   = readyBig;
  assign smallIf.rpt_ready = 1'b1;

  br_perf_monitor #(.CNT_W(32), .HALT_INSN(HALT), .HALT_REPEAT(REPEAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .br_misses_i (brMisses),
    .br_instr_i  (brInstr),
    .instr_i     (instr),
    .t_instr_i   (tInstr),
    .rpt         (bigIf.master),
    .done_o      (done)
  );

  br_perf_monitor #(.CNT_W(4), .HALT_INSN(HALT), .HALT_REPEAT(REPEAT)) dutSmall (
    .clk_i       (clk),
    .rst_i       (rst),
    .br_misses_i (brMisses),
    .br_instr_i  (brInstr),
    .instr_i     (instr),
    .t_instr_i   (tInstr),
    .rpt         (smallIf.master),
    .done_o      (doneSmall)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 64'd15 : v;
  endfunction

  task automatic modelReset();
    mCyc = 0; mBr = 0; mMiss = 0; mSpur = 0; mPc = 0;
    mStreak = 0;
    mRun = 1'b1;
  endtask

  // One clock of probe traffic; the model counts it if the program has not yet halted.
  task automatic applyStimulus(input bit br, input bit miss, input logic [31:0] ins, input logic [31:0] pc);
    bit wasRun;
    wasRun   = mRun;
    brInstr  = br;
    brMisses = miss;
    instr    = ins;
    tInstr   = pc;
    if (mRun) begin
      mCyc++;
      if (br) mBr++;
      if (br && miss) begin
        mMiss++;
        mPc = longint'(pc);
      end
      if (!br && miss) mSpur++;
      mStreak = (ins == HALT) ? mStreak + 1 : 0;
      if (mStreak >= REPEAT) mRun = 1'b0;
    end
    @(posedge clk);
    #1;
    if (wasRun) begin
      checkOutput("valid_vs_halt", 64'(bigIf.rpt_valid), 64'(!mRun));
      checkOutput("done_in_run", 64'(done), 64'd0);
      if (!mRun) checkOutput("idx_at_halt", 64'(bigIf.rpt_idx), 64'd0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 64'(bigIf.rpt_valid), 64'd0);
    checkOutput({tag, "_idx"},   64'(bigIf.rpt_idx),   64'd0);
    checkOutput({tag, "_data"},  64'(bigIf.rpt_data),  64'd0);
    checkOutput({tag, "_last"},  64'(bigIf.rpt_last),  64'd0);
    checkOutput({tag, "_done"},  64'(done),            64'd0);
  endtask

  task automatic doReset(input int n, input logic [31:0] ins);
    rst      = 1'b1;
    brInstr  = 1'b0;
    brMisses = 1'b0;
    instr    = ins;
    tInstr   = 32'd0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkResetState("reset");
  endtask

  task automatic runToHalt(input int bound);
    int k;
    k = 0;
    while (mRun && k < bound) begin
      applyStimulus(1'b0, 1'b0, HALT, 32'd0);
      k++;
    end
    if (mRun) checkOutput("halt_timeout", 64'(bigIf.rpt_valid), 64'd1);
  endtask

  // Drains the report; toggle holds ready low on odd cycles, abortAt resets while that word is shown.
  task automatic collectReport(input bit toggle, input int abortAt);
    longint w [5];
    int got, cyc;
    bit aborted;
    w = '{mCyc, mBr, mMiss, mSpur, mPc & 64'hFFFF_FFFF};
    got = 0; cyc = 0; aborted = 1'b0;
    while (got < 5 && cyc < 40 && !aborted) begin
      if (got == abortAt) begin
        rst      = 1'b1;
        readyBig = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkResetState("abort");
        aborted = 1'b1;
      end else begin
        readyBig = (toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
        checkOutput($sformatf("word%0d_valid", got), 64'(bigIf.rpt_valid), 64'd1);
        checkOutput($sformatf("word%0d_idx", got),   64'(bigIf.rpt_idx),   64'(got));
        checkOutput($sformatf("word%0d_data", got),  64'(bigIf.rpt_data),  64'(w[got]));
        checkOutput($sformatf("word%0d_last", got),  64'(bigIf.rpt_last),  64'(got == 4));
        applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom);
        if (readyBig) got++;
        cyc++;
      end
    end
    if (!aborted) begin
      if (got < 5) begin
        checkOutput("report_timeout", 64'(got), 64'd5);
      end else begin
        checkOutput("done_set",     64'(done),            64'd1);
        checkOutput("done_valid",   64'(bigIf.rpt_valid), 64'd0);
        checkOutput("done_last",    64'(bigIf.rpt_last),  64'd0);
        checkOutput("done_data",    64'(bigIf.rpt_data),  64'(w[4]));
        applyStimulus(1'b1, 1'b1, HALT, 32'h1234);
        checkOutput("done_sticky",  64'(done),            64'd1);
        checkOutput("done_hold",    64'(bigIf.rpt_data),  64'(w[4]));
      end
    end
  endtask

  // The 4-bit instance has ready tied high, so it emits one word per cycle after halting.
  task automatic collectSmall();
    longint w [5];
    w = '{sat4(mCyc), sat4(mBr), sat4(mMiss), sat4(mSpur), mPc & 64'hF};
    readyBig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("small%0d_valid", i), 64'(smallIf.rpt_valid), 64'd1);
      checkOutput($sformatf("small%0d_idx", i),   64'(smallIf.rpt_idx),   64'(i));
      checkOutput($sformatf("small%0d_data", i),  64'(smallIf.rpt_data),  64'(w[i]));
      checkOutput($sformatf("small%0d_last", i),  64'(smallIf.rpt_last),  64'(i == 4));
      applyStimulus(1'b0, 1'b0, NOP, 32'd0);
    end
    checkOutput("small_done",  64'(doneSmall),         64'd1);
    checkOutput("small_valid", 64'(smallIf.rpt_valid), 64'd0);
  endtask

  initial begin
    bit br, miss;
    rst      = 1'b1;
    readyBig = 1'b1;
    brInstr  = 1'b0;
    brMisses = 1'b0;
    instr    = NOP;
    tInstr   = 32'd0;
    modelReset();

    $display("[TB] halt opcode held through and after reset");
    doReset(3, HALT);
    runToHalt(10);
    collectReport(1'b0, -1);

    $display("[TB] ten branches with two mispredicts");
    doReset(2, NOP);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, (i == 3) || (i == 7),
                    NOP, (i == 3) ? 32'h100 : (i == 7) ? 32'h1A0 : 32'(i * 64));
    end
    runToHalt(10);
    collectReport(1'b0, -1);

    $display("[TB] spurious flushes versus branch mispredict");
    doReset(2, NOP);
    applyStimulus(1'b0, 1'b1, NOP, 32'h55);
    applyStimulus(1'b0, 1'b1, NOP, 32'h66);
    applyStimulus(1'b1, 1'b1, NOP, 32'h2C0);
    applyStimulus(1'b0, 1'b0, NOP, 32'h0);
    runToHalt(10);
    collectReport(1'b0, -1);

    $display("[TB] interrupted halt run");
    doReset(2, NOP);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, HALT, 32'd0);
    applyStimulus(1'b1, 1'b0, NOP, 32'd0);
    runToHalt(10);
    collectReport(1'b0, -1);

    $display("[TB] ready toggling, reset at word 2, then clean rerun");
    doReset(2, NOP);
    applyStimulus(1'b1, 1'b1, NOP, 32'hDEAD_BEE0);
    applyStimulus(1'b0, 1'b1, NOP, 32'h0);
    runToHalt(10);
    collectReport(1'b1, 2);
    runToHalt(10);
    collectReport(1'b1, -1);

    $display("[TB] saturation on the 4-bit instance");
    doReset(2, NOP);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, i == 5, NOP, (i == 5) ? 32'h1A7 : 32'h0);
    end
    runToHalt(10);
    collectSmall();

    $display("[TB] random probe traffic");
    for (int r = 0; r < 3; r++) begin
      doReset(1, NOP);
      for (int i = 0; i < 60 && mRun; i++) begin
        br   = 1'($urandom);
        miss = ($urandom_range(0, 3) == 0);
        applyStimulus(br, miss, ($urandom_range(0, 4) == 0) ? HALT : $urandom, $urandom);
      end
      runToHalt(10);
      collectReport(1'(r), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
